// File: rtl/wave_period_meter_if.sv
// wave_period_meter_if -- sample stream and measurement results of the wave
// period meter.
//   sample_en, wave     : qualified 8-bit offset-binary waveform samples
//   period              : last measured period in samples (CNT_W bits)
//   period_valid        : one-cycle pulse when period updates
//   locked              : a valid period is held and no timeout since
//   step_est            : recovered generator step select (period < 192)
//   timeout             : one-cycle pulse on loss of lock
// Modports: master drives samples and reads results; slave is the meter.
interface wave_period_meter_if #(
  parameter int unsigned CNT_W = 12
);
  logic             sample_en;
  logic [7:0]       wave;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             step_est;
  logic             timeout;

  modport master (
    output sample_en, wave,
    input  period, period_valid, locked, step_est, timeout
  );

  modport slave (
    input  sample_en, wave,
    output period, period_valid, locked, step_est, timeout
  );
endinterface

// File: rtl/wave_period_meter.sv
// wave_period_meter -- measures the period, in samples, of the phase-accumulator
// sine generator output by timing rising midscale crossings with hysteresis.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : wave_period_meter_if.slave (sample_en, wave in; period,
//          period_valid, locked, step_est, timeout out; all outputs registered)
// Parameters: HYST (hysteresis around 128), CNT_W (counter/period width),
//   TIMEOUT (samples without a rising event before lock is lost).
// Optional feature: define WPM_AVG_EN to report the average of the last four
// raw periods; without it the raw period is reported directly.
module wave_period_meter #(
  parameter int unsigned HYST    = 8,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned TIMEOUT = 600
) (
  input logic               clk,
  input logic               rst,
  wave_period_meter_if.slave bus
);
  localparam logic [7:0]       LO_TH   = 8'(128 - HYST);
  localparam logic [7:0]       HI_TH   = 8'(128 + HYST);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STEP_TH = CNT_W'(192);

  typedef enum logic {WAIT_LOW, WAIT_HIGH} state_t;

  state_t           state, state_nxt;
  logic             rise, to_hit;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] raw_period;
  logic [CNT_W-1:0] new_period;
  logic             new_valid;

  logic [CNT_W-1:0] period_r;
  logic             period_valid_r, locked_r, step_est_r, timeout_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_LOW;
    else      state <= state_nxt;
  end

  // Timeout is checked on the sample that finds cnt already at TIMEOUT, so an
  // edge arriving on that same sample still measures (period = TIMEOUT+1).
  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    to_hit    = 1'b0;
    if (bus.sample_en) begin
      case (state)
        WAIT_LOW:  if (bus.wave <= LO_TH) state_nxt = WAIT_HIGH;
        WAIT_HIGH: if (bus.wave >= HI_TH) begin
                     state_nxt = WAIT_LOW;
                     rise      = 1'b1;
                   end
        default:   state_nxt = WAIT_LOW;
      endcase
      if (!rise && armed && (cnt == TO_CNT)) begin
        to_hit    = 1'b1;
        state_nxt = WAIT_LOW;
      end
    end
  end

  assign raw_period = cnt + CNT_W'(1);

`ifdef WPM_AVG_EN
  logic [CNT_W-1:0] hist0, hist1, hist2;
  logic [1:0]       hist_n;
  logic [CNT_W+1:0] avg_sum;

  assign avg_sum    = (CNT_W+2)'(raw_period) + (CNT_W+2)'(hist0)
                    + (CNT_W+2)'(hist1) + (CNT_W+2)'(hist2);
  assign new_valid  = rise && armed && (hist_n == 2'd3);
  assign new_period = avg_sum[CNT_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist0  <= '0;
      hist1  <= '0;
      hist2  <= '0;
      hist_n <= '0;
    end else if (to_hit) begin
      hist_n <= '0;
    end else if (rise && armed) begin
      hist2 <= hist1;
      hist1 <= hist0;
      hist0 <= raw_period;
      if (hist_n != 2'd3) hist_n <= hist_n + 2'd1;
    end
  end
`else
  assign new_valid  = rise && armed;
  assign new_period = raw_period;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed          <= 1'b0;
      cnt            <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      step_est_r     <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      period_valid_r <= 1'b0;
      timeout_r      <= 1'b0;
      if (to_hit) begin
        timeout_r <= 1'b1;
        locked_r  <= 1'b0;
        armed     <= 1'b0;
        cnt       <= '0;
      end else if (rise) begin
        armed <= 1'b1;
        cnt   <= '0;
        if (new_valid) begin
          period_r       <= new_period;
          period_valid_r <= 1'b1;
          locked_r       <= 1'b1;
          step_est_r     <= (new_period < STEP_TH);
        end
      end else if (bus.sample_en && armed) begin
        // cnt stays below TO_CNT here, so it cannot wrap
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.locked       = locked_r;
  assign bus.step_est     = step_est_r;
  assign bus.timeout      = timeout_r;
endmodule
